// File: rtl/game_timer_if.sv
// Handshake bundle between the game logic / digit chain and the countdown timer sequencer.
//   start      game -> ctrl   1-cycle pulse: (re)start game
//   pause      game -> ctrl   level: freeze countdown while running
//   stop_req   game -> ctrl   1-cycle pulse: player finished
//   timeout_in chain -> ctrl  LS digit NoBorrowDn (chain reached zero)
//   reconfig   ctrl -> chain  load initial digit values
//   tick       ctrl -> chain  BorrowDn pulse to LS digit
//   running    ctrl -> game   1 while counting or paused
//   timed_out  ctrl -> game   level, 1 once the chain has run out
//   done       ctrl -> game   1-cycle pulse when the game ends
interface game_timer_if;
    logic start;
    logic pause;
    logic stop_req;
    logic timeout_in;
    logic reconfig;
    logic tick;
    logic running;
    logic timed_out;
    logic done;

    modport master (
        output start,
        output pause,
        output stop_req,
        output timeout_in,
        input  reconfig,
        input  tick,
        input  running,
        input  timed_out,
        input  done
    );

    modport slave (
        input  start,
        input  pause,
        input  stop_req,
        input  timeout_in,
        output reconfig,
        output tick,
        output running,
        output timed_out,
        output done
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Sequencer for the countdown digit-timer chain of the Morse game.
// On start it reloads the digit chain (reconfig), then sends one tick to the least-significant
// digit every TICK_DIV clocks while running. It watches the chain's timeout flag, supports
// pause/resume and an early stop, and reports the end of the game.
// Ports:
//   clk  clock
//   rst  synchronous, active-low reset
//   bus  game_timer_if.slave: start/pause/stop_req/timeout_in in,
//        reconfig/tick/running/timed_out/done out (all outputs registered)
module game_timer_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,  // clocks per tick, >= 2
    parameter int unsigned CNT_W    = 26           // 2**CNT_W >= TICK_DIV
) (
    input  logic          clk,
    input  logic          rst,
    game_timer_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArm,
        StRun,
        StPause,
        StTimeout,
        StStopped
    } state_e;

    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TICK_DIV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] psc_q;
    logic             reconfig_q;
    logic             tick_q;
    logic             running_q;
    logic             timed_out_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            psc_q       <= '0;
            reconfig_q  <= 1'b0;
            tick_q      <= 1'b0;
            running_q   <= 1'b0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; only the branches below raise them.
            reconfig_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;

            if (bus.start) begin
                state_q     <= StLoad;
                psc_q       <= '0;
                reconfig_q  <= 1'b1;
                running_q   <= 1'b0;
                timed_out_q <= 1'b0;
            end else begin
                case (state_q)
                    StLoad: begin
                        state_q <= StArm;
                    end
                    // timeout_in is stale here: the chain is clearing it this cycle.
                    StArm: begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                    StRun, StPause: begin
                        if (bus.timeout_in) begin
                            // Any tick due this cycle is dropped.
                            state_q     <= StTimeout;
                            running_q   <= 1'b0;
                            timed_out_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else if (bus.stop_req) begin
                            state_q   <= StStopped;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (bus.pause) begin
                            // Prescaler holds so the tick phase survives the pause.
                            state_q <= StPause;
                        end else begin
                            // Count only on cycles that lead into RUN, so a tick is
                            // always emitted while RUN is visible and none is lost.
                            state_q <= StRun;
                            if (psc_q == TermCnt) begin
                                psc_q  <= '0;
                                tick_q <= 1'b1;
                            end else begin
                                psc_q <= psc_q + CNT_W'(1);
                            end
                        end
                    end
                    StIdle, StTimeout, StStopped: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.reconfig  = reconfig_q;
    assign bus.tick      = tick_q;
    assign bus.running   = running_q;
    assign bus.timed_out = timed_out_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl with TICK_DIV=4: a mode/elapsed-count model checked every cycle,
// plus literal expectations at hand-computed cycle numbers.
module tb_game_timer_ctrl;

    localparam int unsigned TickDiv = 4;

    logic clk;
    logic rst;

    game_timer_if bus ();

    game_timer_ctrl #(
        .TICK_DIV (TickDiv),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cnum     = 0;
    int t0       = 0;

    // Model: game mode plus number of counted cycles since RUN began.
    localparam int MIdle = 0, MLoad = 1, MArm = 2, MRun = 3, MPause = 4, MTout = 5, MStop = 6;
    int   m_mode = MIdle;
    int   m_adv  = 0;
    logic e_tick = 1'b0, e_reconfig = 1'b0, e_done = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cnum);
    endtask

    task automatic model_step();
        e_tick     = 1'b0;
        e_reconfig = 1'b0;
        e_done     = 1'b0;
        if (!rst) begin
            m_mode = MIdle;
            m_adv  = 0;
        end else if (bus.start) begin
            m_mode     = MLoad;
            m_adv      = 0;
            e_reconfig = 1'b1;
        end else begin
            case (m_mode)
                MLoad: m_mode = MArm;
                MArm: begin
                    m_mode = MRun;
                    m_adv  = 0;
                end
                MRun, MPause: begin
                    if (bus.timeout_in) begin
                        m_mode = MTout;
                        e_done = 1'b1;
                    end else if (bus.stop_req) begin
                        m_mode = MStop;
                        e_done = 1'b1;
                    end else if (bus.pause) begin
                        m_mode = MPause;
                    end else begin
                        m_mode = MRun;
                        m_adv++;
                        e_tick = ((m_adv % TickDiv) == 0);
                    end
                end
                default: m_mode = m_mode;
            endcase
        end
    endtask

    task automatic compare_all();
        check("tick",      bus.tick,      e_tick);
        check("reconfig",  bus.reconfig,  e_reconfig);
        check("done",      bus.done,      e_done);
        check("running",   bus.running,   (m_mode == MRun) || (m_mode == MPause));
        check("timed_out", bus.timed_out, m_mode == MTout);
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs compared mid-cycle.
    task automatic cyc();
        @(posedge clk);
        model_step();
        cnum++;
        @(negedge clk);
        compare_all();
    endtask

    function automatic int rel();
        return cnum - t0;
    endfunction

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.stop_req   = 1'b0;
        bus.timeout_in = 1'b0;
        @(negedge clk);
        repeat (3) cyc();
        check("rst_running", bus.running, 1'b0);
        check("rst_tick",    bus.tick,    1'b0);
        rst = 1'b1;
        cyc();

        // pause/stop_req ignored in IDLE
        bus.pause    = 1'b1;
        bus.stop_req = 1'b1;
        cyc();
        bus.pause    = 1'b0;
        bus.stop_req = 1'b0;
        check("idle_done", bus.done, 1'b0);
        cyc();

        // 1. start@c0: reconfig@c1, RUN from c3, ticks @c7,c11,c15
        bus.start = 1'b1;
        t0 = cnum;
        cyc();
        bus.start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) cyc();
            check("t1_reconfig", bus.reconfig, rel() == 1);
            check("t1_tick",     bus.tick,     rel() == 7 || rel() == 11 || rel() == 15);
            check("t1_running",  bus.running,  rel() >= 3);
        end

        // 3. pause for 10 cycles starting 2 cycles after the tick at c15
        cyc();
        bus.pause = 1'b1;
        repeat (10) begin
            cyc();
            check("t3_no_tick", bus.tick, 1'b0);
            check("t3_running", bus.running, 1'b1);
        end
        bus.pause = 1'b0;
        cyc();
        check("t3_tick28", bus.tick, 1'b0);
        cyc();
        check("t3_tick29", bus.tick, 1'b1);

        // 5. restart at c30 (mid-prescale)
        cyc();
        bus.start = 1'b1;
        t0 = cnum;
        cyc();
        bus.start = 1'b0;
        check("t5_reconfig", bus.reconfig, 1'b1);
        check("t5_running",  bus.running,  1'b0);
        for (int i = 2; i <= 8; i++) begin
            cyc();
            check("t5_tick", bus.tick, rel() == 7);
        end

        // 4. stop_req in RUN
        bus.stop_req = 1'b1;
        cyc();
        bus.stop_req = 1'b0;
        check("t4_done",      bus.done,      1'b1);
        check("t4_running",   bus.running,   1'b0);
        check("t4_timed_out", bus.timed_out, 1'b0);
        cyc();
        check("t4_done_once", bus.done, 1'b0);
        bus.stop_req = 1'b1;
        cyc();
        bus.stop_req = 1'b0;
        check("t4_no_redone", bus.done, 1'b0);
        repeat (6) begin
            cyc();
            check("t4_no_tick", bus.tick, 1'b0);
        end

        // 2. timeout_in tied high before start
        bus.timeout_in = 1'b1;
        bus.start      = 1'b1;
        t0 = cnum;
        cyc();
        bus.start = 1'b0;
        check("t2_load_to", bus.timed_out, 1'b0);
        cyc();
        check("t2_arm_to", bus.timed_out, 1'b0);
        cyc();
        check("t2_run",    bus.running,   1'b1);
        cyc();
        check("t2_to",     bus.timed_out, 1'b1);
        check("t2_done",   bus.done,      1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t2_to_hold", bus.timed_out, 1'b1);
            check("t2_done0",   bus.done,      1'b0);
            check("t2_tick0",   bus.tick,      1'b0);
        end
        bus.timeout_in = 1'b0;

        // 6. start and timeout_in together while running: start wins
        bus.start = 1'b1;
        t0 = cnum;
        cyc();
        bus.start = 1'b0;
        repeat (4) cyc();
        bus.start      = 1'b1;
        bus.timeout_in = 1'b1;
        cyc();
        bus.start      = 1'b0;
        bus.timeout_in = 1'b0;
        check("t6_reconfig", bus.reconfig,  1'b1);
        check("t6_done",     bus.done,      1'b0);
        check("t6_timed",    bus.timed_out, 1'b0);
        t0 = cnum - 1;
        repeat (5) cyc();
        // rel 6: prescaler at terminal count, tick would follow; reset instead
        rst = 1'b0;
        cyc();
        check("t6_rst_tick",    bus.tick,    1'b0);
        check("t6_rst_running", bus.running, 1'b0);
        check("t6_rst_done",    bus.done,    1'b0);
        rst = 1'b1;
        repeat (6) begin
            cyc();
            check("t6_idle_tick", bus.tick, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
